// File: rtl/aes_pkg.sv
// Shared AES constants and helpers used by the iterative encrypt and decrypt blocks.
package aes_pkg;

    localparam int unsigned BLOCK_W   = 128;
    localparam int unsigned ROUND_W   = 4;
    localparam int unsigned KEY_W_MAX = 128 * 15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } aes_fsm_t;

    // Entry 0 first: entry x lives at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_FWD[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return SBOX_INV[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Round key 0 sits at the top of the bus, round key nr at [127:0].
    function automatic logic [127:0] round_key(input logic [KEY_W_MAX-1:0] bus,
                                               input logic [ROUND_W-1:0]   round,
                                               input int unsigned          nr);
        logic [10:0] base;
        base = 11'(128 * (nr - 32'(round)));
        return bus[base +: 128];
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational forward AES round; final_round drops MixColumns.
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state,
    input  logic [BLOCK_W-1:0] round_key,
    input  logic               final_round,
    output logic [BLOCK_W-1:0] next_state
);

    logic [7:0]         sb [16];
    logic [7:0]         sr [16];
    logic [7:0]         mc [16];
    logic [BLOCK_W-1:0] sr_flat;
    logic [BLOCK_W-1:0] mc_flat;

    // Byte i is row i%4 of column i/4; row r rotates left by r columns.
    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sb[i] = sbox(state[8*(15-i) +: 8]);
    end

    for (genvar c = 0; c < 4; c++) begin : g_shift_col
        for (genvar r = 0; r < 4; r++) begin : g_shift_row
            assign sr[4*c + r] = sb[4*((c + r) % 4) + r];
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        assign a0 = sr[4*c];
        assign a1 = sr[4*c + 1];
        assign a2 = sr[4*c + 2];
        assign a3 = sr[4*c + 3];
        assign mc[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign mc[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign mc[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign mc[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    for (genvar i = 0; i < 16; i++) begin : g_pack
        assign sr_flat[8*(15-i) +: 8] = sr[i];
        assign mc_flat[8*(15-i) +: 8] = mc[i];
    end

    assign next_state = (final_round ? sr_flat : mc_flat) ^ round_key;

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryptor: one round per clock over an externally held expanded key.
module aes_encrypt_iter
    import aes_pkg::*;
#(
    parameter int unsigned NR    = 14,
    parameter int unsigned KEY_W = 128 * (NR + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BLOCK_W-1:0] plain_in,
    input  logic [KEY_W-1:0]   expanded_key,
    output logic [BLOCK_W-1:0] cipher_out,
    output logic               busy,
    output logic               done
);

    aes_fsm_t           fsm, fsm_next;
    logic [BLOCK_W-1:0] state, state_next;
    logic [BLOCK_W-1:0] cipher_next;
    logic [ROUND_W-1:0] round, round_next;
    logic               busy_next;
    logic               done_next;

    logic [BLOCK_W-1:0] first_key_c;
    logic [BLOCK_W-1:0] round_key_c;
    logic [BLOCK_W-1:0] round_out_c;
    logic               final_c;

    assign first_key_c = round_key(KEY_W_MAX'(expanded_key), ROUND_W'(0), NR);
    assign round_key_c = round_key(KEY_W_MAX'(expanded_key), round, NR);
    assign final_c     = (round == ROUND_W'(NR));

    aes_enc_round u_round (
        .state       (state),
        .round_key   (round_key_c),
        .final_round (final_c),
        .next_state  (round_out_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm        <= ST_IDLE;
            state      <= '0;
            round      <= '0;
            cipher_out <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            fsm        <= fsm_next;
            state      <= state_next;
            round      <= round_next;
            cipher_out <= cipher_next;
            busy       <= busy_next;
            done       <= done_next;
        end
    end

    // Start is only honoured from IDLE, so a request during a block is dropped.
    always_comb begin
        fsm_next    = fsm;
        state_next  = state;
        round_next  = round;
        cipher_next = cipher_out;
        busy_next   = busy;
        done_next   = 1'b0;
        case (fsm)
            ST_IDLE: begin
                busy_next = 1'b0;
                if (start) begin
                    state_next = plain_in ^ first_key_c;
                    round_next = ROUND_W'(1);
                    busy_next  = 1'b1;
                    fsm_next   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (final_c) begin
                    cipher_next = round_out_c;
                    round_next  = '0;
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                    fsm_next    = ST_IDLE;
                end else begin
                    state_next = round_out_c;
                    round_next = round + ROUND_W'(1);
                end
            end
            default: begin
                busy_next = 1'b0;
                fsm_next  = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/aes_encrypt_iter.md
Name: aes_encrypt_iter

Overview:
- Iterative AES encryptor: the forward-cipher counterpart of the team's decrypt block.
- Consumes the same flattened expanded-key bus that KeyExpansion produces, and performs one cipher round per clock.
- Start/busy/done handshake. Default configuration is AES-256 (14 rounds); AES-128 and AES-192 are selectable by parameter.
- Sits between KeyExpansion and the board-level top, feeding the decrypt block for loop-back checks.

Parameters:
- NR, 14, number of rounds; legal values 10, 12, 14.
- KEY_W, 128*(NR+1), width of the expanded-key bus.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to encrypt plain_in; sampled only while idle.
- plain_in  input  128  plaintext block; FIPS-197 byte order, byte 0 = bits [127:120].
- expanded_key  input  KEY_W  round keys:
  - round key 0 = bits [KEY_W-1 : KEY_W-128];
  - round key r = next 128 bits down;
  - round key NR = bits [127:0].
- cipher_out  output  128  ciphertext; registered, held until the next completion.
- busy  output  1  high while a block is in flight.
- done  output  1  single-cycle pulse when cipher_out is updated.

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE.
  - state register, cipher_out and round counter cleared to 0.
  - busy=0, done=0.
  - Reset mid-operation aborts the block; no done pulse is produced.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE and start=1, on the clock edge:
  - state <= plain_in XOR round key 0;
  - round <= 1;
  - go to RUN.
- RUN with round < NR, on the clock edge:
  - state <= MixColumns(ShiftRows(SubBytes(state))) XOR round key[round];
  - round <= round+1.
- RUN with round == NR, on the clock edge (final round, no MixColumns):
  - cipher_out <= ShiftRows(SubBytes(state)) XOR round key NR;
  - done <= 1 for exactly one cycle;
  - go to IDLE; busy <= 0.
- Latency:
  - start sampled at edge T gives done=1 and a valid cipher_out after edge T+NR.
  - This is 14 cycles for AES-256 and 10 for AES-128.
- start while busy=1 is ignored. No queueing, no error flag.
- start is accepted in the cycle where done=1, because the FSM is already IDLE there. Back-to-back throughput is one block per NR+1 cycles.
- plain_in is captured only at the start edge and may change afterwards.
- expanded_key is not latched. It must stay stable from the start edge until done. This matches KeyExpansion's static combinational output.
- The round counter is 4 bits and is never compared beyond NR. It does not wrap during normal operation.
- cipher_out and done are registered outputs: no combinational path from inputs.
- Arithmetic:
  - MixColumns uses GF(2^8) with polynomial 0x11B; xtime(b) = (b<<1) XOR (b[7] ? 0x1B : 0).
  - All XORs are 128-bit, with no width extension.
- SubBytes uses the forward S-box only. No inverse tables appear in this block.

Decomposition:
- Shared package aes_pkg holds:
  - forward and inverse S-box constant tables;
  - xtime and gmul functions;
  - the round-key slice function, which takes (bus, round, NR) and returns 128 bits;
  - FSM state encoding.
  - The decrypt block migrates to the same package.
- One combinational sub-module, aes_enc_round: inputs state, round_key and final_round; output next_state. The FSM, counter and handshake stay in aes_encrypt_iter.

Test Plan:
1. AES-256 FIPS-197 C.3:
   - Stimulus: key 000102...1e1f through KeyExpansion(8,14), plain 00112233445566778899aabbccddeeff, start pulse.
   - Required: done exactly 14 cycles after start; cipher_out = 8ea2b7ca516745bfeafc49904b496089; busy high for exactly 14 cycles.
2. AES-128 (NR=10) FIPS-197 Appendix B:
   - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, plain 3243f6a8885a308d313198a2e0370734.
   - Required: cipher_out = 3925841d02dc09fbdc118597196a0b32 after 10 cycles.
3. Start while busy:
   - Stimulus: pulse start with a different plain_in at cycle 5 of a block.
   - Required: ignored; the first result is unchanged; exactly one done pulse.
4. Back-to-back blocks:
   - Stimulus: assert start in the done cycle with plain 00..00 (AES-256 key above).
   - Required: second done 14 cycles later; first cipher_out held until the second done.
5. Reset mid-operation:
   - Stimulus: assert rst at round 7.
   - Required: busy=0, done=0, cipher_out=0 immediately (asynchronous); no done pulse follows; a subsequent start produces the correct C.3 result.
6. Loop-back:
   - Stimulus: feed cipher_out into the decrypt block with the same expanded_key.
   - Required: recovered plaintext equals the original for 100 random plaintexts.
